// File: rtl/sobel_pkg.sv
// Shared types and widths for the Sobel gradient path.
// Optional build macro used by sobel_gradient: SOBEL_REPLICATE_EDGE_EN.
package sobel_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int GRAD_WIDTH  = 11;

    typedef logic [PIXEL_WIDTH-1:0]        pixel_t;
    typedef logic signed [GRAD_WIDTH-1:0]  grad_t;
    typedef logic [PIXEL_WIDTH+1:0]        wsum_t;

    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } column_t;

    // Difference of two unsigned weighted sums as a signed gradient.
    // Operands are zero-extended first, so the result cannot overflow.
    function automatic grad_t wdiff(input wsum_t a, input wsum_t b);
        logic [GRAD_WIDTH-1:0] ea;
        logic [GRAD_WIDTH-1:0] eb;
        ea = GRAD_WIDTH'(a);
        eb = GRAD_WIDTH'(b);
        return grad_t'(ea - eb);
    endfunction

endpackage

// File: rtl/sobel_weight3.sv
// Combinational 1-2-1 weighted sum of three pixels.
// Ports: p0, p1, p2 pixels in; sum = p0 + 2*p1 + p2 out.
module sobel_weight3
    import sobel_pkg::*;
(
    input  pixel_t p0,
    input  pixel_t p1,
    input  pixel_t p2,
    output wsum_t  sum
);

    assign sum = wsum_t'(p0) + wsum_t'({p1, 1'b0}) + wsum_t'(p2);

endmodule

// File: rtl/sobel_gradient.sv
// Sliding 3x3 window and 2-stage Sobel gx/gy pipeline feeding the magnitude stage.
// Ports: clk, reset (sync, active-high); colTop/colMid/colBot, inValid,
//   rowStart, stall in; gx, gy (signed), outValid (one-cycle pulse) out.
// Build macro SOBEL_REPLICATE_EDGE_EN: replicate the first column of a row
//   as the left edge, giving N-1 results per N-column row instead of N-2.
module sobel_gradient
    import sobel_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PIXEL_WIDTH-1:0]       colTop,
    input  logic [PIXEL_WIDTH-1:0]       colMid,
    input  logic [PIXEL_WIDTH-1:0]       colBot,
    input  logic                         inValid,
    input  logic                         rowStart,
    input  logic                         stall,
    output logic signed [GRAD_WIDTH-1:0] gx,
    output logic signed [GRAD_WIDTH-1:0] gy,
    output logic                         outValid
);

    column_t l_q, l_d, c_q, c_d, r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic full_q, full_d;
    wsum_t colw_l_q, colw_l_d, colw_r_q, colw_r_d;
    wsum_t roww_t_q, roww_t_d, roww_b_q, roww_b_d;
    logic v1_q, v1_d;
    grad_t gx_q, gx_d, gy_q, gy_d;
    logic ov_q, ov_d;

    column_t new_col;
    wsum_t colw_l, colw_r, roww_t, roww_b;
    logic accept;
    logic full_hit;

    assign new_col = '{top: colTop, mid: colMid, bot: colBot};
    assign accept  = inValid & ~stall;
    // Window completes on a non-rowStart accept once two columns are
    // already held; with edge replication rowStart preloads cnt to 2.
    assign full_hit = accept & ~rowStart & (cnt_q >= 2'd2);

    sobel_weight3 u_colw_l (
        .p0(l_q.top), .p1(l_q.mid), .p2(l_q.bot), .sum(colw_l)
    );
    sobel_weight3 u_colw_r (
        .p0(r_q.top), .p1(r_q.mid), .p2(r_q.bot), .sum(colw_r)
    );
    sobel_weight3 u_roww_t (
        .p0(l_q.top), .p1(c_q.top), .p2(r_q.top), .sum(roww_t)
    );
    sobel_weight3 u_roww_b (
        .p0(l_q.bot), .p1(c_q.bot), .p2(r_q.bot), .sum(roww_b)
    );

    always_comb begin
        l_d      = l_q;
        c_d      = c_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        colw_l_d = colw_l_q;
        colw_r_d = colw_r_q;
        roww_t_d = roww_t_q;
        roww_b_d = roww_b_q;
        v1_d     = v1_q;
        gx_d     = gx_q;
        gy_d     = gy_q;
        ov_d     = ov_q;
        if (!stall) begin
            full_d = full_hit;
            v1_d   = full_q;
            ov_d   = v1_q;
            if (full_q) begin
                colw_l_d = colw_l;
                colw_r_d = colw_r;
                roww_t_d = roww_t;
                roww_b_d = roww_b;
            end
            if (v1_q) begin
                gx_d = wdiff(colw_r_q, colw_l_q);
                gy_d = wdiff(roww_b_q, roww_t_q);
            end
            if (accept) begin
                if (rowStart) begin
`ifdef SOBEL_REPLICATE_EDGE_EN
                    l_d   = new_col;
                    c_d   = new_col;
                    r_d   = new_col;
                    cnt_d = 2'd2;
`else
                    l_d   = c_q;
                    c_d   = r_q;
                    r_d   = new_col;
                    cnt_d = 2'd1;
`endif
                end else begin
                    l_d   = c_q;
                    c_d   = r_q;
                    r_d   = new_col;
                    cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            colw_l_q <= '0;
            colw_r_q <= '0;
            roww_t_q <= '0;
            roww_b_q <= '0;
            v1_q     <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            ov_q     <= 1'b0;
        end else begin
            l_q      <= l_d;
            c_q      <= c_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            colw_l_q <= colw_l_d;
            colw_r_q <= colw_r_d;
            roww_t_q <= roww_t_d;
            roww_b_q <= roww_b_d;
            v1_q     <= v1_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            ov_q     <= ov_d;
        end
    end

    assign gx       = gx_q;
    assign gy       = gy_q;
    assign outValid = ov_q;

endmodule
